multicycle_ctrl_fsm: RTL
========================

# multicycle_ctrl_fsm

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states instead of decoding in a single cycle. It handshakes with a shared instruction/data memory that has variable latency, and traps on illegal encodings or memory timeouts. It sits between the instruction register / ALU flags and every datapath enable and mux select.

## Interface
- ALU_W, 3, width of alu_sel (encodings: ADD=0, SUB=1, XOR=2, SLT=3; other codes unused)
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ack before trap (1..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26]
- funct  in  6  instruction register bits [5:0]
- alu_zero  in  1  ALU result == 0, valid in EXEC
- mem_ack  in  1  memory transfer complete this cycle
- mem_req  out  1  memory access request
- mem_wr  out  1  request is a store
- ir_wr_en  out  1  load instruction register
- pc_wr_en  out  1  load PC
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (JR)
- reg_wr_en  out  1  register file write
- reg_dst  out  2  0 = rd, 1 = rt, 2 = r31
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+8
- alu_sel  out  ALU_W  ALU operation
- alu_src_imm  out  1  ALU B operand = immediate
- imm_zero_ext  out  1  zero-extend immediate (XORI)
- retire  out  1  one-cycle pulse, instruction complete
- illegal  out  1  sticky, unsupported encoding trapped
- bus_error  out  1  sticky, memory timeout trapped

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset enters FETCH.
- Supported instructions: R-type (op 0) ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08; J 0x02; JAL 0x03; ADDI 0x08; XORI 0x0E; BEQ 0x04; BNE 0x05; LW 0x23; SW 0x2B.
- FETCH: mem_req=1, mem_wr=0, pc_sel=0. On mem_ack: ir_wr_en=1 and pc_wr_en=1 (PC←PC+4), then go to DECODE.
- DECODE: latch opcode/funct into internal registers; all later states decode from the latched copy. An unsupported opcode, or op 0 with an unsupported funct, sets illegal and goes to TRAP. Otherwise go to EXEC.
- EXEC drives alu_sel/alu_src_imm/imm_zero_ext per instruction. Arithmetic uses ADD/SUB/SLT. ADDI uses ADD with imm. XORI uses XOR with imm and zero-ext. LW/SW use ADD with imm. BEQ/BNE use SUB.
  - R-arith, ADDI, XORI: go to WB.
  - LW/SW: go to MEM.
  - J: pc_wr_en=1, pc_sel=2, retire, go to FETCH.
  - JAL: pc_wr_en=1, pc_sel=2, reg_wr_en=1, reg_dst=2, wb_sel=2, retire, go to FETCH.
  - JR: pc_wr_en=1, pc_sel=3, retire, go to FETCH.
  - BEQ: pc_wr_en=alu_zero. BNE: pc_wr_en=!alu_zero. Both use pc_sel=1, retire, go to FETCH.
- MEM: mem_req=1, mem_wr=1 for SW. On mem_ack: SW retires and goes to FETCH; LW goes to WB.
- WB: reg_wr_en=1, retire, go to FETCH. Settings:
  - R-type: reg_dst=0, wb_sel=0.
  - ADDI/XORI: reg_dst=1, wb_sel=0.
  - LW: reg_dst=1, wb_sel=1.
- Wait counter: cleared on entry to FETCH or MEM and increments each cycle without mem_ack. If the counter equals MEM_TIMEOUT with no ack, set bus_error and go to TRAP; mem_req drops the next cycle.
- TRAP: all enables and mem_req are 0. The FSM stays here until rst_n is asserted.
- Outputs not listed for a state are 0.

## Timing
- Reset values: every output 0, state FETCH, wait counter 0, illegal=0, bus_error=0. The first mem_req is asserted the first cycle after rst_n deasserts.
- mem_ack is combinational into ir_wr_en, pc_wr_en and the next state. An ack in the same cycle as mem_req completes the access. mem_ack is ignored when mem_req=0.
- Latency in cycles with zero-wait memory: J/JAL/JR/BEQ/BNE 3, R-type/ADDI/XORI 4, SW 4, LW 5. Each memory wait cycle adds 1.
- mem_req stays high and constant until ack or timeout; no request is ever withdrawn early.
- Timeout fires with an ack exactly on wait cycle MEM_TIMEOUT → ack wins (access completes, no trap).
- retire is asserted in the final cycle of the instruction, coincident with its last write enable.
- Asynchronous reset mid-instruction clears all state at once; no partial writes are issued afterwards.

## Test plan
- ADD (op 0, funct 0x20), mem_ack tied high → FETCH,DECODE,EXEC,WB. WB cycle shows reg_wr_en=1, reg_dst=0, wb_sel=0, alu_sel=0, retire=1. Total 4 cycles.
- LW with mem_ack delayed 3 cycles in MEM → mem_req held 4 cycles, then WB with wb_sel=1, reg_dst=1. Total 8 cycles.
- BEQ twice, alu_zero=1 then alu_zero=0 → pc_wr_en=1 with pc_sel=1 in EXEC for the first, pc_wr_en=0 for the second. Both retire in 3 cycles.
- JAL → EXEC shows pc_sel=2, reg_dst=2, wb_sel=2, reg_wr_en=1. Next cycle is FETCH.
- Opcode 0x3F, and separately op 0 with funct 0x00 → illegal=1 after DECODE. Enables stay 0 for 20 cycles. rst_n pulse clears illegal.
- mem_ack held low in FETCH with MEM_TIMEOUT=15 → bus_error=1 after 15 wait cycles. Repeat with ack on cycle 15 → no trap.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes
// with a variable-latency shared memory and traps on bad encodings or timeouts.
module multicycle_ctrl_fsm #(
    parameter int ALU_W       = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             ir_wr_en,
    output logic             pc_wr_en,
    output logic [1:0]       pc_sel,
    output logic             reg_wr_en,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic [ALU_W-1:0] alu_sel,
    output logic             alu_src_imm,
    output logic             imm_zero_ext,
    output logic             retire,
    output logic             illegal,
    output logic             bus_error
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,
        K_SUB  = 4'd1,
        K_SLT  = 4'd2,
        K_JR   = 4'd3,
        K_J    = 4'd4,
        K_JAL  = 4'd5,
        K_ADDI = 4'd6,
        K_XORI = 4'd7,
        K_BEQ  = 4'd8,
        K_BNE  = 4'd9,
        K_LW   = 4'd10,
        K_SW   = 4'd11,
        K_BAD  = 4'd15
    } kind_t;

    // Instruction class for one opcode/funct pair; K_BAD for anything unsupported.
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        k = K_BAD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  k = K_ADD;
                    FN_SUB:  k = K_SUB;
                    FN_SLT:  k = K_SLT;
                    FN_JR:   k = K_JR;
                    default: k = K_BAD;
                endcase
            end
            OP_J:    k = K_J;
            OP_JAL:  k = K_JAL;
            OP_BEQ:  k = K_BEQ;
            OP_BNE:  k = K_BNE;
            OP_ADDI: k = K_ADDI;
            OP_XORI: k = K_XORI;
            OP_LW:   k = K_LW;
            OP_SW:   k = K_SW;
            default: k = K_BAD;
        endcase
        return k;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic        active_r;
    logic [5:0]  op_r;
    logic [5:0]  fn_r;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nxt_s;
    logic        illegal_r;
    logic        bus_error_r;
    logic        set_illegal_s;
    logic        set_bus_err_s;
    logic        timeout_s;
    kind_t       kind_s;

    assign kind_s    = classify(op_r, fn_r);
    assign timeout_s = (wait_cnt_r == TIMEOUT_C);
    assign illegal   = illegal_r;
    assign bus_error = bus_error_r;

    // Next-state and datapath control decode; active_r keeps outputs quiet until the first clock after reset.
    always_comb begin
        state_nxt_s    = state_r;
        set_illegal_s  = 1'b0;
        set_bus_err_s  = 1'b0;
        mem_req        = 1'b0;
        mem_wr         = 1'b0;
        ir_wr_en       = 1'b0;
        pc_wr_en       = 1'b0;
        pc_sel         = 2'd0;
        reg_wr_en      = 1'b0;
        reg_dst        = 2'd0;
        wb_sel         = 2'd0;
        alu_sel        = ALU_ADD;
        alu_src_imm    = 1'b0;
        imm_zero_ext   = 1'b0;
        retire         = 1'b0;
        wait_cnt_nxt_s = 8'd0;

        if (!active_r) begin
            state_nxt_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_wr_en    = 1'b1;
                        pc_wr_en    = 1'b1;
                        state_nxt_s = ST_DECODE;
                    end else if (timeout_s) begin
                        set_bus_err_s = 1'b1;
                        state_nxt_s   = ST_TRAP;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (classify(opcode, funct) == K_BAD) begin
                        set_illegal_s = 1'b1;
                        state_nxt_s   = ST_TRAP;
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (kind_s)
                        K_ADD: begin
                            alu_sel     = ALU_ADD;
                            state_nxt_s = ST_WB;
                        end
                        K_SUB: begin
                            alu_sel     = ALU_SUB;
                            state_nxt_s = ST_WB;
                        end
                        K_SLT: begin
                            alu_sel     = ALU_SLT;
                            state_nxt_s = ST_WB;
                        end
                        K_ADDI: begin
                            alu_sel     = ALU_ADD;
                            alu_src_imm = 1'b1;
                            state_nxt_s = ST_WB;
                        end
                        K_XORI: begin
                            alu_sel      = ALU_XOR;
                            alu_src_imm  = 1'b1;
                            imm_zero_ext = 1'b1;
                            state_nxt_s  = ST_WB;
                        end
                        K_LW, K_SW: begin
                            alu_sel     = ALU_ADD;
                            alu_src_imm = 1'b1;
                            state_nxt_s = ST_MEM;
                        end
                        K_J: begin
                            pc_wr_en    = 1'b1;
                            pc_sel      = 2'd2;
                            retire      = 1'b1;
                            state_nxt_s = ST_FETCH;
                        end
                        K_JAL: begin
                            pc_wr_en    = 1'b1;
                            pc_sel      = 2'd2;
                            reg_wr_en   = 1'b1;
                            reg_dst     = 2'd2;
                            wb_sel      = 2'd2;
                            retire      = 1'b1;
                            state_nxt_s = ST_FETCH;
                        end
                        K_JR: begin
                            pc_wr_en    = 1'b1;
                            pc_sel      = 2'd3;
                            retire      = 1'b1;
                            state_nxt_s = ST_FETCH;
                        end
                        K_BEQ, K_BNE: begin
                            alu_sel     = ALU_SUB;
                            pc_sel      = 2'd1;
                            pc_wr_en    = (kind_s == K_BEQ) ? alu_zero : ~alu_zero;
                            retire      = 1'b1;
                            state_nxt_s = ST_FETCH;
                        end
                        default: begin
                            set_illegal_s = 1'b1;
                            state_nxt_s   = ST_TRAP;
                        end
                    endcase
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_wr  = (kind_s == K_SW);
                    if (mem_ack) begin
                        if (kind_s == K_SW) begin
                            retire      = 1'b1;
                            state_nxt_s = ST_FETCH;
                        end else begin
                            state_nxt_s = ST_WB;
                        end
                    end else if (timeout_s) begin
                        set_bus_err_s = 1'b1;
                        state_nxt_s   = ST_TRAP;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end
                ST_WB: begin
                    reg_wr_en   = 1'b1;
                    retire      = 1'b1;
                    state_nxt_s = ST_FETCH;
                    if (kind_s == K_LW) begin
                        reg_dst = 2'd1;
                        wb_sel  = 2'd1;
                    end else if ((kind_s == K_ADDI) || (kind_s == K_XORI)) begin
                        reg_dst = 2'd1;
                        wb_sel  = 2'd0;
                    end else begin
                        reg_dst = 2'd0;
                        wb_sel  = 2'd0;
                    end
                end
                ST_TRAP: begin
                    state_nxt_s = ST_TRAP;
                end
                default: begin
                    state_nxt_s = ST_TRAP;
                end
            endcase
        end

        // Counter restarts whenever a request is not outstanding, so entry to FETCH/MEM starts at zero.
        if (mem_req && !mem_ack && !timeout_s) begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_nxt_s = 8'd0;
        end
    end

    // State, wait counter and sticky trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            active_r    <= 1'b0;
            wait_cnt_r  <= 8'd0;
            illegal_r   <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            active_r    <= 1'b1;
            wait_cnt_r  <= wait_cnt_nxt_s;
            illegal_r   <= illegal_r | set_illegal_s;
            bus_error_r <= bus_error_r | set_bus_err_s;
        end
    end

    // Instruction fields are captured in DECODE; later states ignore the live IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 6'd0;
            fn_r <= 6'd0;
        end else if (state_r == ST_DECODE) begin
            op_r <= opcode;
            fn_r <= funct;
        end else begin
            op_r <= op_r;
            fn_r <= fn_r;
        end
    end

endmodule
